det4x4_minor_engine: RTL
========================

// Module: det4x4_minor_engine
// PURPOSE
//  Sequential 4x4 determinant unit: the responder on the start/done minor-evaluation handshake that
//  the 5x5 Laplace-expansion controller drives once per cofactor. It captures one packed 4x4 minor,
//  expands along row 0 through four 3x3 minors on a shared multiplier path, then returns the signed
//  determinant with done. The caller samples det on the rising edge of done.
// PARAMETERS
//  DATA_W   8   width of each unsigned matrix element
//  DET_W    32  width of the signed det output; exact internal result is ACC_W = 4*DATA_W+6 bits
// PORTS
//  clk       in   1    single clock, all logic on rising edge
//  reset     in   1    synchronous, active-high
//  matriz_A  in   200  packed minor: element (r,c), r,c in 0..3, at bits [r*40 + c*8 +: 8];
//                      byte 4 of each 40-bit row and bits [199:160] are ignored
//  start     in   1    level request; held high for the whole operation
//  done      out  1    result valid; held high while start stays high
//  det       out  DET_W  signed two's-complement determinant
// BEHAVIOUR
//  - Reset: done=0, det=0, state=IDLE, accumulators=0. Reset has priority over every other input.
//  - Elements are unsigned. Result is signed. Accumulation is exact in ACC_W bits.
//  - FSM states: IDLE -> LOAD_MINOR -> TERM -> SCALE -> (LOAD_MINOR | DONE) -> WAIT_LOW -> IDLE.
//  - IDLE: on the edge that samples start=1, register matriz_A into a 4x4 matrix copy and set k=0.
//    Later input changes are ignored.
//  - TERM: 6 cycles. Cycle t adds or subtracts one triple product of the 3x3 minor that excludes
//    row 0 and column k (Sarrus order, signs + + + - - -).
//  - SCALE: 1 cycle. acc += (-1)^k * a[0][k] * minor. Then k++; after k=3, go to DONE.
//  - Latency: done rises exactly 28 rising edges after the edge that sampled start.
//    The caller sees done=1 in the cycle after the 28th edge (4 x (6+1)).
//  - DONE: det and done registered on the same edge. Both hold while start=1.
//  - Deassert: start=0 in DONE or WAIT_LOW -> next edge done=0, det=0, state=IDLE.
//  - Re-arm: a new operation needs start low for >=1 cycle. A start held high after done never retriggers.
//  - Abort: start=0 in any compute state -> next edge IDLE, accumulators cleared, done stays 0.
//  - Reset mid-operation: same as abort, plus all registers return to their reset values.
//  - Narrowing to DET_W: see CONFIGURATION. When DET_W >= ACC_W the output is the sign-extended exact result.
// CONFIGURATION
//  DET4X4_SAT_EN defined:
//    - Exact result outside the signed DET_W range clamps to 2^(DET_W-1)-1 or to -2^(DET_W-1).
//  DET4X4_SAT_EN undefined:
//    - det = exact[DET_W-1:0] (wrap-around).
//    - No clamp logic is synthesised.
// STRUCTURE
//  - Package det_pkg holds:
//    - DATA_W default and ROW_STRIDE=40.
//    - function acc_w(data_w).
//    - State enum {IDLE, LOAD_MINOR, TERM, SCALE, DONE, WAIT_LOW}.
//    - Constant table MINOR_COLS[k] = the three column indices kept for cofactor k.
//    - Sarrus sign vector 6'b000111.
//  - Sub-module det3_minor_mac: takes a 3x3 operand set and a term index 0..5, and accumulates one
//    signed triple product per enabled cycle. It holds the 2-multiplier path.
//  - Top level keeps the FSM, the k counter, the SCALE multiplier and the output narrowing.
// TESTING
//  - Identity (diag 1, garbage 0xAA in the ignored bytes and bits [199:160]) -> done at +28, det=1.
//  - Upper triangular, diag 2,3,4,5, off-diagonal 7 -> det=120.
//    Then hold start 5 more cycles -> done and det stable.
//    Then drop start -> next cycle done=0, det=0.
//  - Identity with rows 0 and 1 swapped -> det=32'hFFFF_FFFF (-1).
//  - diag 255 x4:
//    - SAT_EN undefined -> det=32'hFC05_FC01.
//    - SAT_EN defined -> det=32'h7FFF_FFFF.
//  - Start identity, drop start at cycle 10 -> done never rises.
//    Then, after 1 low cycle, start the diag-2,3,4,5 matrix -> det=120 at +28 with no residue from the abort.
//  - Assert reset at cycle 15 of an operation with start still high -> done=0, det=0.
//    After reset releases, the FSM waits for start low, then high, before computing again.

Source files
------------

// File: rtl/det_pkg.sv
// Shared definitions for the 4x4 determinant engine.
//   DATA_W_DEFAULT : default element width
//   ROW_STRIDE     : bit distance between rows of the packed input minor
//   acc_w()        : exact accumulator width for a given element width
//   state_e        : controller states
//   MINOR_COLS     : columns kept in the 3x3 minor for each row-0 cofactor k
//   SARRUS_POS     : bit t set when Sarrus triple product t is added
package det_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned ROW_STRIDE     = 40;

    function automatic int unsigned acc_w(input int unsigned data_w);
        return 4 * data_w + 6;
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StLoadMinor,
        StTerm,
        StScale,
        StDone,
        StWaitLow
    } state_e;

    localparam logic [1:0] MINOR_COLS [4][3] = '{
        '{2'd1, 2'd2, 2'd3},
        '{2'd0, 2'd2, 2'd3},
        '{2'd0, 2'd1, 2'd3},
        '{2'd0, 2'd1, 2'd2}
    };

    localparam logic [5:0] SARRUS_POS = 6'b000111;

endpackage

// File: rtl/det3_minor_mac.sv
// 3x3 determinant accumulator: one Sarrus triple product per enabled cycle.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : clear the running minor (abort)
//   en_i    : accumulate term term_i this cycle
//   first_i : start a new minor (ignore the previous running value)
//   term_i  : Sarrus term index 0..5
//   m_i     : 3x3 unsigned operands, m_i[row][col]
//   minor_o : signed running minor
module det3_minor_mac
    import det_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned MIN_W  = 3 * DATA_W + 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clr_i,
    input  logic                            en_i,
    input  logic                            first_i,
    input  logic [2:0]                      term_i,
    input  logic [2:0][2:0][DATA_W-1:0]     m_i,
    output logic signed [MIN_W-1:0]         minor_o
);

    logic signed [MIN_W-1:0]  minor_q, minor_d;
    logic signed [MIN_W-1:0]  term_s, base;
    logic [1:0]               c0, c1, c2;
    logic                     pos;
    logic [DATA_W-1:0]        e0, e1, e2;
    logic [2*DATA_W-1:0]      p1;
    logic [3*DATA_W-1:0]      p2;

    always_comb begin
        c0  = 2'd0;
        c1  = 2'd1;
        c2  = 2'd2;
        pos = 1'b0;
        unique case (term_i)
            3'd0: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; pos = SARRUS_POS[0]; end
            3'd1: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; pos = SARRUS_POS[1]; end
            3'd2: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; pos = SARRUS_POS[2]; end
            3'd3: begin c0 = 2'd2; c1 = 2'd1; c2 = 2'd0; pos = SARRUS_POS[3]; end
            3'd4: begin c0 = 2'd0; c1 = 2'd2; c2 = 2'd1; pos = SARRUS_POS[4]; end
            3'd5: begin c0 = 2'd1; c1 = 2'd0; c2 = 2'd2; pos = SARRUS_POS[5]; end
            default: ;
        endcase

        e0     = m_i[0][c0];
        e1     = m_i[1][c1];
        e2     = m_i[2][c2];
        p1     = e0 * e1;
        p2     = p1 * e2;
        term_s = MIN_W'(p2);

        base    = first_i ? '0 : minor_q;
        minor_d = minor_q;
        if (clr_i) begin
            minor_d = '0;
        end else if (en_i) begin
            minor_d = pos ? base + term_s : base - term_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            minor_q <= '0;
        end else begin
            minor_q <= minor_d;
        end
    end

    assign minor_o = minor_q;

endmodule

// File: rtl/det4x4_minor_engine.sv
// Sequential 4x4 determinant by row-0 Laplace expansion over four 3x3 minors.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   matriz_A : packed 4x4 minor, element (r,c) at [r*40 + c*8 +: 8]
//   start    : level request, held high for the whole operation
//   done     : result valid, held while start stays high
//   det      : signed determinant, DET_W bits
// Optional macro DET4X4_SAT_EN: clamp the narrowed result instead of wrapping.
// Each cofactor takes 7 cycles: LOAD_MINOR (term 0), TERM (terms 1..5), SCALE;
// done is registered on the final SCALE edge, 28 edges after the start edge.
module det4x4_minor_engine
    import det_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DET_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [199:0]            matriz_A,
    input  logic                    start,
    output logic                    done,
    output logic signed [DET_W-1:0] det
);

    localparam int unsigned ACC_W  = acc_w(DATA_W);
    localparam int unsigned MIN_W  = 3 * DATA_W + 3;
    localparam int unsigned PROD_W = MIN_W + DATA_W + 1;

`ifdef DET4X4_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        (DET_W < ACC_W) ? ACC_W'((longint'(1) <<< (DET_W - 1)) - 1) : '0;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
`endif

    function automatic logic [DET_W-1:0] narrow(input logic signed [ACC_W-1:0] x);
`ifdef DET4X4_SAT_EN
        if (DET_W < ACC_W) begin
            if (x > SAT_MAX) return {1'b0, {(DET_W - 1){1'b1}}};
            if (x < SAT_MIN) return {1'b1, {(DET_W - 1){1'b0}}};
        end
`endif
        return DET_W'(x);
    endfunction

    state_e                          state_q, state_d;
    logic [1:0]                      k_q, k_d;
    logic [2:0]                      t_q, t_d;
    logic [3:0][3:0][DATA_W-1:0]     a_q, a_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [DET_W-1:0]                det_q, det_d;
    logic                            done_q, done_d;
    // Start only counts as a new request after it has been seen low.
    logic                            start_low_q;

    logic                            mac_en, mac_first, mac_clr;
    logic [2:0]                      mac_term;
    logic [2:0][2:0][DATA_W-1:0]     mac_m;
    logic signed [MIN_W-1:0]         minor;
    logic signed [DATA_W:0]          a0k_s;
    logic signed [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]         acc_new;
    logic                            unused_ign_bits;

    assign unused_ign_bits = ^{matriz_A[199:160], matriz_A[159:152], matriz_A[119:112],
                               matriz_A[79:72], matriz_A[39:32]};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                mac_m[i][j] = a_q[i + 1][MINOR_COLS[k_q][j]];
            end
        end
        a0k_s   = {1'b0, a_q[0][k_q]};
        prod    = a0k_s * minor;
        acc_new = k_q[0] ? acc_q - ACC_W'(prod) : acc_q + ACC_W'(prod);
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        t_d       = t_q;
        a_d       = a_q;
        acc_d     = acc_q;
        det_d     = det_q;
        done_d    = done_q;
        mac_en    = 1'b0;
        mac_first = 1'b0;
        mac_clr   = 1'b0;
        mac_term  = (state_q == StLoadMinor) ? 3'd0 : t_q;

        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                det_d  = '0;
                if (start && start_low_q) begin
                    for (int r = 0; r < 4; r++) begin
                        for (int c = 0; c < 4; c++) begin
                            a_d[r][c] = matriz_A[r * ROW_STRIDE + c * DATA_W +: DATA_W];
                        end
                    end
                    k_d     = 2'd0;
                    acc_d   = '0;
                    state_d = StLoadMinor;
                end
            end
            StLoadMinor, StTerm, StScale: begin
                if (!start) begin
                    state_d = StIdle;
                    k_d     = 2'd0;
                    t_d     = 3'd0;
                    acc_d   = '0;
                    mac_clr = 1'b1;
                end else if (state_q == StLoadMinor) begin
                    mac_en    = 1'b1;
                    mac_first = 1'b1;
                    t_d       = 3'd1;
                    state_d   = StTerm;
                end else if (state_q == StTerm) begin
                    mac_en = 1'b1;
                    if (t_q == 3'd5) begin
                        t_d     = 3'd0;
                        state_d = StScale;
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end else begin
                    acc_d = acc_new;
                    if (k_q == 2'd3) begin
                        det_d   = narrow(acc_new);
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = StLoadMinor;
                    end
                end
            end
            StDone, StWaitLow: begin
                if (!start) begin
                    done_d  = 1'b0;
                    det_d   = '0;
                    acc_d   = '0;
                    state_d = StIdle;
                end else begin
                    state_d = StWaitLow;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            t_q         <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            det_q       <= '0;
            done_q      <= 1'b0;
            start_low_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            det_q       <= det_d;
            done_q      <= done_d;
            start_low_q <= !start;
        end
    end

    det3_minor_mac #(
        .DATA_W (DATA_W),
        .MIN_W  (MIN_W)
    ) u_mac (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (mac_clr),
        .en_i    (mac_en),
        .first_i (mac_first),
        .term_i  (mac_term),
        .m_i     (mac_m),
        .minor_o (minor)
    );

    assign done = done_q;
    assign det  = det_q;

endmodule
